// File: rtl/count_controller.sv
// Button front end for the up/down counter pair: run/pause toggle, tick prescaler, swap latch.
// Define COUNT_STEP_EN to add a BotaoStep single-step button that is honoured only in pause.
module count_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRESCALE        = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BotaoRun,
  input  logic BotaoSwap,
`ifdef COUNT_STEP_EN
  input  logic BotaoStep,
`endif
  output logic Enable,
  output logic Swap,
  output logic Running
);

  localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PreW    = $clog2(PRESCALE);
  localparam int unsigned BtnRun  = 0;
  localparam int unsigned BtnSwap = 1;
`ifdef COUNT_STEP_EN
  localparam int unsigned BtnStep = 2;
  localparam int unsigned NumBtn  = 3;
`else
  localparam int unsigned NumBtn  = 2;
`endif

  typedef enum logic {StPause, StRun} state_e;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] deb_q, deb_d;
  logic [NumBtn-1:0] press_evt;
  logic [CntW-1:0]   deb_cnt_q [NumBtn];
  logic [CntW-1:0]   deb_cnt_d [NumBtn];

  state_e          state_q, state_d;
  logic            running_q;
  logic            run_active;
  logic            tick;
  logic [PreW-1:0] pre_q, pre_d;
  logic            swap_pend_q, swap_pend_d;
  logic            step_svc;
  logic            enable_q, enable_d;
  logic            swap_q, swap_d;

`ifdef COUNT_STEP_EN
  assign btn_raw = {BotaoStep, BotaoSwap, BotaoRun};
`else
  assign btn_raw = {BotaoSwap, BotaoRun};
`endif

  // A level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      press_evt[i] = 1'b0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i]     = sync2_q[i];
          press_evt[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (press_evt[BtnRun]) begin
      state_d = (state_q == StRun) ? StPause : StRun;
    end
  end

  // The prescaler waits for Running so the first tick lands PRESCALE cycles after it rises.
  assign run_active = (state_q == StRun) && running_q;
  assign tick       = run_active && (pre_q == PreW'(PRESCALE - 1));

  always_comb begin
    pre_d = '0;
    if (run_active && !tick) begin
      pre_d = pre_q + PreW'(1);
    end
  end

  // A pending swap is always serviced on the next edge; events landing then are merged.
  assign swap_pend_d = swap_pend_q ? 1'b0 : press_evt[BtnSwap];

`ifdef COUNT_STEP_EN
  logic step_pend_q, step_pend_d;

  always_comb begin
    step_pend_d = step_pend_q;
    if (step_pend_q && !swap_pend_q) begin
      step_pend_d = 1'b0;
    end
    if (press_evt[BtnStep] && (state_q == StPause)) begin
      step_pend_d = 1'b1;
    end
  end

  assign step_svc = step_pend_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign step_svc = 1'b0;
`endif

  always_comb begin
    enable_d = 1'b0;
    swap_d   = 1'b0;
    if (swap_pend_q) begin
      enable_d = 1'b1;
      swap_d   = 1'b1;
    end else if (step_svc || tick) begin
      enable_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        deb_cnt_q[i] <= '0;
      end
      state_q     <= StPause;
      running_q   <= 1'b0;
      pre_q       <= '0;
      swap_pend_q <= 1'b0;
      enable_q    <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      for (int i = 0; i < NumBtn; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      state_q     <= state_d;
      running_q   <= (state_q == StRun);
      pre_q       <= pre_d;
      swap_pend_q <= swap_pend_d;
      enable_q    <= enable_d;
      swap_q      <= swap_d;
    end
  end

  assign Enable  = enable_q;
  assign Swap    = swap_q;
  assign Running = running_q;

endmodule

// File: doc/count_controller.md
Name: count_controller

Overview:
- Control stage directly upstream of the up/down counter pair.
- Turns two raw pushbuttons into the counter's Enable and Swap controls.
  - BotaoRun: run/pause toggle.
  - BotaoSwap: swap request.
- Contains synchronisers, debouncers, a run/pause FSM, a tick prescaler and a swap-request latch.
- All outputs are registered, one Enable/Swap pair per cycle, wired straight to the counter's Enable and Swap inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes; legal range >= 1.
- PRESCALE, 8: clock cycles per count tick in RUN; legal range >= 2.

Ports:
- Clock  input  1  single rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- BotaoRun  input  1  raw asynchronous run/pause button; 1 = pressed.
- BotaoSwap  input  1  raw asynchronous swap button; 1 = pressed.
- Enable  output  1  counter enable; registered.
- Swap  output  1  counter swap select; registered; only ever 1 together with Enable.
- Running  output  1  1 while FSM is in RUN; registered.

Behaviour:
- Clocking: one clock domain, rising edge of Clock. Reset is synchronous and active-high.
- Reset values: Enable=0, Swap=0, Running=0, FSM=PAUSE, prescaler=0, swap-pending=0, synchronisers=0, debounced levels=0, debounce counters=0.
- Reset mid-operation: any pending swap is discarded and any tick in flight is lost.
- Synchroniser: each button passes through 2 flops (sync1, sync2).
- Debounce, per button:
  - counter width = clog2(DEBOUNCE_CYCLES+1).
  - On each edge where sync2 != deb: the counter increments; on the DEBOUNCE_CYCLES-th consecutive mismatch, deb takes sync2 and the counter clears.
  - On any edge where sync2 == deb, the counter clears.
- Event: generated combinationally when deb is about to flip 0->1 (press only; releases generate nothing).
- FSM states: PAUSE, RUN.
  - PAUSE -> RUN on run event.
  - RUN -> PAUSE on run event.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN.
  - tick = (RUN and count == PRESCALE-1); count wraps to 0 on tick.
  - Cleared to 0 on the RUN->PAUSE transition, so the first tick after resuming comes exactly PRESCALE cycles later.
- Swap-pending flag:
  - Set on swap event, in either state.
  - Cleared on the edge where it is serviced.
  - A swap event while already pending is merged (no double swap).
- Output register, next-state values:
  - pending=1: Enable=1, Swap=1, pending clears. Any tick in the same cycle is dropped; the prescaler still wraps normally.
  - else tick: Enable=1, Swap=0.
  - else: Enable=0, Swap=0.
- Pulse widths: Enable and Swap are single-cycle pulses. Consecutive swap pulses are at least 2 cycles apart, because the debounce re-arm prevents anything tighter.
- Simultaneous run and swap events: both act. FSM toggles and pending sets in the same edge; the swap is still serviced on the next edge regardless of the new state.
- Latency: counting the first edge that samples a held press into sync1 as edge 1:
  - debounced level flips at edge DEBOUNCE_CYCLES+2;
  - Swap/Enable (or Running) rises at edge DEBOUNCE_CYCLES+3 (edge 7 at default).
- Glitches: a press shorter than DEBOUNCE_CYCLES stable sync2 samples produces no event.

Optional Feature:
- Macro: COUNT_STEP_EN.
- Defined:
  - Adds port BotaoStep (input, 1, raw step button) with the same sync/debounce/event path.
  - A step event in PAUSE produces exactly one Enable=1, Swap=0 pulse at the output edge following the event.
  - Priority: pending swap wins; the step is then serviced the following cycle.
  - Step events in RUN are ignored.
- Undefined: the port and its logic are absent; behaviour otherwise identical.

Test Plan (DEBOUNCE_CYCLES=4, PRESCALE=8):
- Reset held 3 cycles, then released with buttons idle 20 cycles -> Enable=Swap=Running=0 throughout.
- BotaoRun pulsed high 10 cycles -> Running=1 at edge 7 after the first sampling edge; Enable pulses (Swap=0) every 8 cycles, first pulse 8 cycles after Running rises; counter Up advances 1 per pulse.
- In RUN, BotaoRun pressed again -> Running=0 at press edge 7, no further Enable pulses; resume again -> first Enable exactly 8 cycles after Running rises.
- In PAUSE with counters Down=13, Up=2, BotaoSwap held 10 cycles -> single cycle with Enable=1 and Swap=1 at edge 7; counters become Down=2, Up=13; no second swap.
- BotaoSwap glitch high for 3 cycles -> no Swap. Swap press timed so service coincides with a tick -> only the swap pulse appears in that cycle, and the next Enable comes 8 cycles later.
- Reset asserted one cycle after a swap event, before service -> Swap never asserts, all state back to reset values.
